div_iter: RTL and testbench

- Multi-cycle iterative radix-2 restoring divider; the responder side of the execute stage's divide handshake (start/annul in, result/ready out).
- Computes quotient and remainder of two 32-bit operands, signed or unsigned. One quotient bit is produced per clock.
- Result is returned as {remainder, quotient} in a 64-bit word. The requester stalls the pipeline while ready_o is low.

---
 rtl/div_iter.sv | 133 +++++++++++++
 tb/tb_div_iter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Returns {remainder, quotient}; signed mode works on magnitudes and fixes up signs at the end.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]    dsr_q, dsr_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic                sgn_q, sgn_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                dsr_neg_q, dsr_neg_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic [WIDTH-1:0]    mag1, mag2;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    quot_fix, rem_fix;

    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
    assign quot_fix = (sgn_q && (dvd_neg_q != dsr_neg_q)) ? -dvd_q : dvd_q;
    assign rem_fix  = (sgn_q && dvd_neg_q) ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        result_d  = '0;
        ready_d   = 1'b0;

        unique case (state_q)
            StFree: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = StByZero;
                    end else begin
                        state_d   = StOn;
                        dvd_d     = mag1;
                        dsr_d     = mag2;
                        sgn_d     = signed_div_i;
                        dvd_neg_d = opdata1_i[WIDTH-1];
                        dsr_neg_d = opdata2_i[WIDTH-1];
                        rem_d     = '0;
                        cnt_d     = '0;
                    end
                end
            end
            StByZero: begin
                state_d = StEnd;
                dvd_d   = '0;
                rem_d   = '0;
                sgn_d   = 1'b0;
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StFree;
                end else begin
                    rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StEnd;
                    end
                end
            end
            StEnd: begin
                if (start_i && !annul_i) begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    state_d = StFree;
                end
            end
            default: state_d = StFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus random operands against an
// arithmetic reference model (truncating division, remainder takes the dividend's sign).
module tb_div_iter;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div;
    logic [W-1:0]   op1, op2;
    logic           start, annul;
    logic [2*W-1:0] result;
    logic           ready;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == 0) return '0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Raise start with the given operands and wait (bounded) for ready; start stays high.
    task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int scramble_at, output int cycles, output logic [2*W-1:0] res);
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        cycles = 0;
        res    = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ready) begin
                cycles = i;
                res    = result;
                break;
            end
            if (i == scramble_at) begin
                op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
            end
        end
    endtask

    task automatic release_div();
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset: ready=%b result=%h, want ready=0 result=0", ready, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int c; logic [2*W-1:0] r;
        do_div(1'b0, 32'd100, 32'd7, 0, c, r);
        n_checks++;
        if (c !== 34) begin
            n_fail++; $display("FAIL unsigned_latency: got %0d want 34", c);
        end
        n_checks++;
        if (r !== {32'd2, 32'd14}) begin
            n_fail++; $display("FAIL unsigned_100_7: got %h want %h", r, {32'd2, 32'd14});
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || result !== '0) begin
            n_fail++; $display("FAIL drop_start: ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_signed();
        int c; logic [2*W-1:0] r;
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, c, r);
        n_checks++;
        if (r !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
            n_fail++; $display("FAIL signed_m100_7: got %h want fffffffefffffff2", r);
        end
        release_div();
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0, c, r);
        n_checks++;
        if (r !== {32'd2, 32'hFFFF_FFF2}) begin
            n_fail++; $display("FAIL signed_100_m7: got %h want 00000002fffffff2", r);
        end
        release_div();
    endtask

    task automatic test_div_zero();
        int c; logic [2*W-1:0] r;
        do_div(1'b0, 32'h1234_5678, 32'd0, 0, c, r);
        n_checks++;
        if (c !== 3 || r !== '0) begin
            n_fail++; $display("FAIL div_zero: latency=%0d result=%h want 3/0", c, r);
        end
        release_div();
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, c, r);
        n_checks++;
        if (r !== {32'd0, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL div_one: got %h want 00000000ffffffff", r);
        end
        release_div();
    endtask

    task automatic test_extremes();
        int c; logic [2*W-1:0] r;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, c, r);
        n_checks++;
        if (r !== {32'd0, 32'h8000_0000}) begin
            n_fail++; $display("FAIL signed_overflow: got %h want 0000000080000000", r);
        end
        release_div();
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, c, r);
        n_checks++;
        if (r !== {32'h8000_0000, 32'd0}) begin
            n_fail++; $display("FAIL unsigned_extreme: got %h want 8000000000000000", r);
        end
        release_div();
    endtask

    task automatic test_annul();
        int c, highs; logic [2*W-1:0] r, exp;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1; annul = 1'b0;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; annul = 1'b0;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_fail++; $display("FAIL annul_no_ready: ready high %0d cycles want 0", highs);
        end
        do_div(1'b0, 32'd50, 32'd5, 0, c, r);
        n_checks++;
        if (c !== 34 || r !== {32'd0, 32'd10}) begin
            n_fail++; $display("FAIL after_annul: latency=%0d result=%h want 34/%h",
                               c, r, {32'd0, 32'd10});
        end
        release_div();
        exp = ref_div(1'b1, 32'hFFFF_D8F1, 32'd37);
        do_div(1'b1, 32'hFFFF_D8F1, 32'd37, 5, c, r);
        n_checks++;
        if (c !== 34 || r !== exp) begin
            n_fail++; $display("FAIL operand_change: latency=%0d result=%h want 34/%h", c, r, exp);
        end
        release_div();
    endtask

    task automatic test_reset_mid();
        int c, highs; logic [2*W-1:0] r, exp;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd123456; op2 = 32'd789; start = 1'b1; annul = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || result !== '0) begin
            n_fail++; $display("FAIL reset_mid: ready=%b result=%h want 0/0", ready, result);
        end
        rst = 1'b0; start = 1'b0;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_fail++; $display("FAIL reset_abort: ready high %0d cycles want 0", highs);
        end
        exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, c, r);
        n_checks++;
        if (c !== 34 || r !== exp) begin
            n_fail++; $display("FAIL post_reset: latency=%0d result=%h want 34/%h", c, r, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || result !== exp) begin
                n_fail++; $display("FAIL hold_end[%0d]: ready=%b result=%h want 1/%h",
                                   i, ready, result, exp);
            end
        end
        release_div();
    endtask

    task automatic test_back_to_back();
        int c; logic [2*W-1:0] r, exp;
        do_div(1'b0, 32'd1000, 32'd10, 0, c, r);
        n_checks++;
        if (r !== {32'd0, 32'd100}) begin
            n_fail++; $display("FAIL b2b_first: got %h want %h", r, {32'd0, 32'd100});
        end
        // Annul in END acts like dropping start; start still high then launches the next op.
        annul = 1'b1; signed_div = 1'b1; op1 = 32'hFFFF_FFB3; op2 = 32'd5;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || result !== '0) begin
            n_fail++; $display("FAIL b2b_clear: ready=%b result=%h want 0/0", ready, result);
        end
        annul = 1'b0;
        exp = ref_div(1'b1, 32'hFFFF_FFB3, 32'd5);
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ready) begin
                c = i; r = result; break;
            end
        end
        n_checks++;
        if (c !== 34 || r !== exp) begin
            n_fail++; $display("FAIL b2b_second: latency=%0d result=%h want 34/%h", c, r, exp);
        end
        release_div();
    endtask

    task automatic test_random();
        int c, want_c; logic [2*W-1:0] r, exp; logic s; logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 255);
                default: ;
            endcase
            exp    = ref_div(s, a, b);
            want_c = (b == 0) ? 3 : 34;
            do_div(s, a, b, 0, c, r);
            n_checks++;
            if (c !== want_c || r !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] s=%b %h/%h: latency=%0d result=%h want %0d/%h",
                         i, s, a, b, c, r, want_c, exp);
            end
            release_div();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_extremes();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
